hazard_suspend_ctrl: RTL and testbench

HAZARD_SUSPEND_CTRL -- requirements
Module: hazard_suspend_ctrl

---
 rtl/hazard_suspend_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_suspend_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_suspend_ctrl.sv
// rtl/hazard_suspend_ctrl.sv - RAW hazard suspend controller for an in-order pipeline
//
// Purpose:
//   Detects read-after-write hazards between the instruction in ID and the
//   producers in EX, MEM and WB. It suspends issue for a stage-dependent
//   number of cycles. An EX-resolved branch/jump flush overrides any suspend.
//
// Ports:
//   clk_i            pipeline clock, rising edge
//   rst_i            asynchronous active-high reset
//   id_valid_i       ID holds a valid instruction
//   id_rs1_i/rs2_i   ID source register indices
//   id_rs*_used_i    source is a real operand
//   ex/mem/wb_rd_i   stage destination register
//   ex/mem/wb_we_i   stage writes the register file
//   ex_flush_i       taken branch/jump resolved in EX
//   pc_stall_o       hold the PC
//   if_id_stall_o    hold the IF/ID register
//   id_ex_bubble_o   load a NOP into ID/EX
//   if_id_flush_o    clear IF/ID
//   suspending_o     FSM is in SUSPEND
//   stall_cnt_o      saturating count of stalled cycles

module hazard_suspend_ctrl #(
  parameter int EX_STALL  = 3,
  parameter int MEM_STALL = 2,
  parameter int WB_STALL  = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       mem_rd_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             ex_we_i,
  input  logic             mem_we_i,
  input  logic             wb_we_i,
  input  logic             ex_flush_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             id_ex_bubble_o,
  output logic             if_id_flush_o,
  output logic             suspending_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int MAX_EM    = (EX_STALL > MEM_STALL) ? EX_STALL : MEM_STALL;
  localparam int MAX_STALL = (MAX_EM > WB_STALL) ? MAX_EM : WB_STALL;
  localparam int RW        = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);

  localparam logic [RW-1:0] EX_N  = RW'(EX_STALL);
  localparam logic [RW-1:0] MEM_N = RW'(MEM_STALL);
  localparam logic [RW-1:0] WB_N  = RW'(WB_STALL);
  localparam logic [RW-1:0] ONE   = RW'(1);

  typedef enum logic {IDLE, SUSPEND} state_t;

  state_t           state_q;
  logic [RW-1:0]    rem_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic          ex_hit, mem_hit, wb_hit;
  logic [RW-1:0] need;
  logic          hazard;
  logic          stall_req;

  // x0 is hardwired zero, so it can never be a true producer.
  assign ex_hit  = id_valid_i && ex_we_i && (ex_rd_i != 5'd0) &&
                   ((id_rs1_used_i && (ex_rd_i == id_rs1_i)) ||
                    (id_rs2_used_i && (ex_rd_i == id_rs2_i)));
  assign mem_hit = id_valid_i && mem_we_i && (mem_rd_i != 5'd0) &&
                   ((id_rs1_used_i && (mem_rd_i == id_rs1_i)) ||
                    (id_rs2_used_i && (mem_rd_i == id_rs2_i)));
  assign wb_hit  = id_valid_i && wb_we_i && (wb_rd_i != 5'd0) &&
                   ((id_rs1_used_i && (wb_rd_i == id_rs1_i)) ||
                    (id_rs2_used_i && (wb_rd_i == id_rs2_i)));

  // The youngest producer decides the wait; an older match is already
  // covered by the longer wait of the younger one.
  always_comb begin
    need = '0;
    if (ex_hit)       need = EX_N;
    else if (mem_hit) need = MEM_N;
    else if (wb_hit)  need = WB_N;
  end

  // Hazards are only evaluated in IDLE; during SUSPEND the inserted bubbles
  // are already draining the producer.
  assign hazard    = (state_q == IDLE) && (need != '0);
  assign stall_req = (state_q == SUSPEND) || hazard;

  // Flush wins over any stall; all requests are masked while in reset.
  assign pc_stall_o     = !rst_i && stall_req && !ex_flush_i;
  assign if_id_stall_o  = !rst_i && stall_req && !ex_flush_i;
  assign id_ex_bubble_o = !rst_i && (stall_req || ex_flush_i);
  assign if_id_flush_o  = !rst_i && ex_flush_i;
  assign suspending_o   = (state_q == SUSPEND);
  assign stall_cnt_o    = stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end

      if (ex_flush_i) begin
        state_q <= IDLE;
        rem_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (hazard) begin
              // The detection cycle itself is the first stall cycle.
              rem_q   <= need - ONE;
              state_q <= (need != ONE) ? SUSPEND : IDLE;
            end
          end
          SUSPEND: begin
            if (rem_q <= ONE) begin
              state_q <= IDLE;
              rem_q   <= '0;
            end else begin
              rem_q <= rem_q - ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            rem_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_suspend_ctrl.sv
// tb/tb_hazard_suspend_ctrl.sv - directed scoreboard bench for hazard_suspend_ctrl

module tb_hazard_suspend_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       id_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i;
  logic       id_rs1_used_i, id_rs2_used_i;
  logic [4:0] ex_rd_i, mem_rd_i, wb_rd_i;
  logic       ex_we_i, mem_we_i, wb_we_i;
  logic       ex_flush_i;
  logic       pc_stall_o, if_id_stall_o, id_ex_bubble_o, if_id_flush_o, suspending_o;
  logic [3:0] stall_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sbq[$];

  hazard_suspend_ctrl #(
    .EX_STALL (3),
    .MEM_STALL(2),
    .WB_STALL (1),
    .CNT_W    (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_i       (ex_rd_i),
    .mem_rd_i      (mem_rd_i),
    .wb_rd_i       (wb_rd_i),
    .ex_we_i       (ex_we_i),
    .mem_we_i      (mem_we_i),
    .wb_we_i       (wb_we_i),
    .ex_flush_i    (ex_flush_i),
    .pc_stall_o    (pc_stall_o),
    .if_id_stall_o (if_id_stall_o),
    .id_ex_bubble_o(id_ex_bubble_o),
    .if_id_flush_o (if_id_flush_o),
    .suspending_o  (suspending_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clr();
    id_valid_i    = 1'b0;
    id_rs1_i      = 5'd0;
    id_rs2_i      = 5'd0;
    id_rs1_used_i = 1'b0;
    id_rs2_used_i = 1'b0;
    ex_rd_i       = 5'd0;
    mem_rd_i      = 5'd0;
    wb_rd_i       = 5'd0;
    ex_we_i       = 1'b0;
    mem_we_i      = 1'b0;
    wb_we_i       = 1'b0;
    ex_flush_i    = 1'b0;
  endtask

  task automatic ex_haz();
    clr();
    id_valid_i    = 1'b1;
    ex_rd_i       = 5'd5;
    ex_we_i       = 1'b1;
    id_rs1_i      = 5'd5;
    id_rs1_used_i = 1'b1;
  endtask

  task automatic wb_haz();
    clr();
    id_valid_i    = 1'b1;
    wb_rd_i       = 5'd9;
    wb_we_i       = 1'b1;
    id_rs1_i      = 5'd9;
    id_rs1_used_i = 1'b1;
  endtask

  // Called one time unit after a rising edge: queue the expectation, sample
  // mid-cycle, then advance to one unit past the next rising edge.
  task automatic chk(input string tag, input logic pc, input logic ifid,
                     input logic bub, input logic fl, input logic susp,
                     input logic [3:0] cnt);
    exp_t       e;
    logic [8:0] obs;
    e.tag = tag;
    e.v   = {pc, ifid, bub, fl, susp, cnt};
    sbq.push_back(e);
    #3;
    e   = sbq.pop_front();
    obs = {pc_stall_o, if_id_stall_o, id_ex_bubble_o, if_id_flush_o, suspending_o, stall_cnt_o};
    vectors++;
    assert (obs === e.v) else begin
      miscompares++;
      $error("FAIL %s: observed pc/ifid/bub/fl/susp/cnt=%b required %b", e.tag, obs, e.v);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    clr();
    #1;
    // Reset masks everything, even with a hazard and a flush present.
    rst_i      = 1'b1;
    ex_haz();
    ex_flush_i = 1'b1;
    chk("rst_hold",  0, 0, 0, 0, 0, 4'd0);
    chk("rst_hold2", 0, 0, 0, 0, 0, 4'd0);
    rst_i = 1'b0;
    clr();
    chk("idle_quiet", 0, 0, 0, 0, 0, 4'd0);

    // EX producer: three stall cycles, SUSPEND on cycles 2-3.
    ex_haz();
    chk("ex_c1", 1, 1, 1, 0, 0, 4'd0);
    chk("ex_c2", 1, 1, 1, 0, 1, 4'd1);
    chk("ex_c3", 1, 1, 1, 0, 1, 4'd2);
    clr();
    chk("ex_issue", 0, 0, 0, 0, 0, 4'd3);

    // MEM producer on rs2: two stall cycles.
    id_valid_i    = 1'b1;
    mem_rd_i      = 5'd7;
    mem_we_i      = 1'b1;
    id_rs2_i      = 5'd7;
    id_rs2_used_i = 1'b1;
    chk("mem_c1", 1, 1, 1, 0, 0, 4'd3);
    chk("mem_c2", 1, 1, 1, 0, 1, 4'd4);
    clr();
    chk("mem_issue", 0, 0, 0, 0, 0, 4'd5);

    // WB producer: one stall cycle, never enters SUSPEND.
    wb_haz();
    chk("wb_c1", 1, 1, 1, 0, 0, 4'd5);
    clr();
    chk("wb_issue", 0, 0, 0, 0, 0, 4'd6);

    // MEM and WB both match: the younger MEM count applies.
    id_valid_i    = 1'b1;
    mem_rd_i      = 5'd7;
    mem_we_i      = 1'b1;
    wb_rd_i       = 5'd7;
    wb_we_i       = 1'b1;
    id_rs1_i      = 5'd7;
    id_rs1_used_i = 1'b1;
    chk("pri_c1", 1, 1, 1, 0, 0, 4'd6);
    chk("pri_c2", 1, 1, 1, 0, 1, 4'd7);
    clr();
    chk("pri_issue", 0, 0, 0, 0, 0, 4'd8);

    // No-hazard cases.
    clr();
    id_valid_i    = 1'b1;
    ex_rd_i       = 5'd0;
    ex_we_i       = 1'b1;
    id_rs1_i      = 5'd0;
    id_rs1_used_i = 1'b1;
    chk("nh_x0", 0, 0, 0, 0, 0, 4'd8);
    ex_haz();
    id_rs1_used_i = 1'b0;
    id_rs2_i      = 5'd5;
    chk("nh_unused", 0, 0, 0, 0, 0, 4'd8);
    ex_haz();
    id_valid_i = 1'b0;
    chk("nh_invalid", 0, 0, 0, 0, 0, 4'd8);

    // Flush in cycle 2 of an EX suspend.
    clr();
    rst_i = 1'b1;
    chk("rst_again", 0, 0, 0, 0, 0, 4'd0);
    rst_i = 1'b0;
    ex_haz();
    chk("fl_c1", 1, 1, 1, 0, 0, 4'd0);
    ex_flush_i = 1'b1;
    chk("fl_c2", 0, 0, 1, 1, 1, 4'd1);
    clr();
    chk("fl_after", 0, 0, 0, 0, 0, 4'd1);

    // Flush coinciding with a new hazard in IDLE.
    ex_haz();
    ex_flush_i = 1'b1;
    chk("fli_c1", 0, 0, 1, 1, 0, 4'd1);
    clr();
    chk("fli_after", 0, 0, 0, 0, 0, 4'd1);

    // Asynchronous reset between edges while suspending.
    ex_haz();
    chk("ar_c1", 1, 1, 1, 0, 0, 4'd1);
    chk("ar_c2", 1, 1, 1, 0, 1, 4'd2);
    rst_i = 1'b1;
    chk("ar_rst", 0, 0, 0, 0, 0, 4'd0);
    rst_i = 1'b0;
    clr();
    chk("ar_release",  0, 0, 0, 0, 0, 4'd0);
    chk("ar_release2", 0, 0, 0, 0, 0, 4'd0);

    // Twenty back-to-back WB hazards saturate the 4-bit counter.
    wb_haz();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sat_%0d", k), 1, 1, 1, 0, 0, (k < 15) ? 4'(k) : 4'd15);
    end
    clr();
    chk("sat_hold", 0, 0, 0, 0, 0, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
